// File: rtl/tt_scan_driver.sv
// -----------------------------------------------------------------------------
// tt_scan_driver
//
// Exhaustive stimulus/capture driver for single-output combinational netlists.
// Walks every input vector 0 .. 2^N_IN-1 in ascending order on x_o, samples the
// netlist output y_i once per vector and packs the samples into OUT_W-bit
// truth-table words, which are streamed out over a valid/ready handshake.
//
// Parameters:
//   N_IN      number of netlist inputs (1..16)
//   OUT_W     truth-table word width (power of two, divides 2^N_IN, >= 2)
//   EVAL_LAT  cycles between an x_o change and a valid y_i (0 = combinational)
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   start                 begin a scan (only honoured in IDLE)
//   busy, done            scan in progress / one-cycle completion pulse
//   x_o                   input vector driven onto the netlist
//   y_i                   netlist output y0
//   tt_data, tt_valid,
//   tt_ready, tt_last     truth-table word stream; bit j = f(word*OUT_W + j)
//   sig, sig_valid        (TT_SCAN_SIG_EN only) CRC-16-CCITT of all samples
//
// Build option:
//   TT_SCAN_SIG_EN  adds the sig/sig_valid signature outputs.
//
// States:
//   S_IDLE  | waiting for start, x_o = 0
//   S_DRIVE | x_o = idx presented (first cycle of the evaluation window)
//   S_WAIT  | holding x_o while the netlist output settles (EVAL_LAT > 0)
//   S_EMIT  | full word presented on tt_data, waiting for tt_ready
//   S_DONE  | one-cycle completion pulse
// -----------------------------------------------------------------------------
module tt_scan_driver #(
    parameter int N_IN     = 8,
    parameter int OUT_W    = 16,
    parameter int EVAL_LAT = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [N_IN-1:0]   x_o,
    input  logic              y_i,
    output logic [OUT_W-1:0]  tt_data,
    output logic              tt_valid,
    input  logic              tt_ready,
    output logic              tt_last
`ifdef TT_SCAN_SIG_EN
    ,
    output logic [15:0]       sig,
    output logic              sig_valid
`endif
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_DRIVE = 3'd1,
        S_WAIT  = 3'd2,
        S_EMIT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // The WAIT down-counter is loaded with EVAL_LAT-1 in DRIVE, so DRIVE plus
    // the WAIT cycles span exactly EVAL_LAT+1 cycles of a stable x_o.
    localparam int CNT_LOAD_I = (EVAL_LAT > 0) ? EVAL_LAT - 1 : 0;
    localparam int CNT_W      = (CNT_LOAD_I > 0) ? $clog2(CNT_LOAD_I + 1) : 1;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CNT_LOAD_I);
    localparam logic [N_IN-1:0]  BIT_MASK = N_IN'(OUT_W - 1);

    state_t             state_q, state_d;
    logic [N_IN-1:0]    idx_q, idx_d;
    logic [OUT_W-1:0]   word_q, word_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               sample_now;
    logic               word_end;
    logic               idx_last;

    assign sample_now = ((state_q == S_DRIVE) && (EVAL_LAT == 0)) ||
                        ((state_q == S_WAIT) && (cnt_q == '0));
    assign word_end   = ((idx_q & BIT_MASK) == BIT_MASK);
    assign idx_last   = (idx_q == '1);

    // ---------------------------------------------------------------- state reg
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // --------------------------------------------------------------- next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_DRIVE;
            end
            S_DRIVE: begin
                if (EVAL_LAT > 0)  state_d = S_WAIT;
                else if (word_end) state_d = S_EMIT;
                else               state_d = S_DRIVE;
            end
            S_WAIT: begin
                if (cnt_q == '0) state_d = word_end ? S_EMIT : S_DRIVE;
            end
            S_EMIT: begin
                if (tt_ready) state_d = idx_last ? S_DONE : S_DRIVE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------ outputs
    always_comb begin
        busy     = 1'b0;
        done     = 1'b0;
        tt_valid = 1'b0;
        tt_last  = 1'b0;
        case (state_q)
            S_DRIVE, S_WAIT: busy = 1'b1;
            S_EMIT: begin
                busy     = 1'b1;
                tt_valid = 1'b1;
                tt_last  = idx_last;
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    assign x_o     = idx_q;
    assign tt_data = word_q;

    // ---------------------------------------------------------------- datapath
    always_comb begin
        idx_d  = idx_q;
        word_d = word_q;
        cnt_d  = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    idx_d  = '0;
                    word_d = '0;
                end
            end
            S_DRIVE: cnt_d = CNT_LOAD;
            S_WAIT: begin
                if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
            end
            S_EMIT: begin
                if (tt_ready && !idx_last) begin
                    idx_d  = idx_q + N_IN'(1);
                    word_d = '0;
                end
            end
            S_DONE:  idx_d = '0;
            default: ;
        endcase
        // The word register is cleared before each word, so OR-ing the
        // sample into its bit position is enough.
        if (sample_now) begin
            word_d = word_q | (OUT_W'(y_i) << (idx_q & BIT_MASK));
            if (!word_end) idx_d = idx_q + N_IN'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q  <= '0;
            word_q <= '0;
            cnt_q  <= '0;
        end else begin
            idx_q  <= idx_d;
            word_q <= word_d;
            cnt_q  <= cnt_d;
        end
    end

`ifdef TT_SCAN_SIG_EN
    // CRC-16-CCITT, MSB-first, one sampled bit per step.
    localparam logic [15:0] CRC_POLY = 16'h1021;

    logic [15:0] sig_q, sig_d;

    always_comb begin
        sig_d = sig_q;
        if ((state_q == S_IDLE) && start) begin
            sig_d = 16'hFFFF;
        end else if (sample_now) begin
            sig_d = {sig_q[14:0], 1'b0} ^ ((sig_q[15] ^ y_i) ? CRC_POLY : 16'h0000);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q <= 16'hFFFF;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig       = sig_q;
    assign sig_valid = (state_q == S_DONE);
`endif

endmodule

// File: tb/tb_tt_scan_driver.sv
module tb_tt_scan_driver;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    // default-parameter instance, combinational netlist model
    logic        start0 = 1'b0;
    logic        busy0, done0, tt_valid0, tt_last0;
    logic        tt_ready0 = 1'b1;
    logic [7:0]  x0;
    logic [15:0] tt_data0;
    logic        y0;
    int          ymode = 0;

    // EVAL_LAT=2 instance, 2-stage registered parity netlist
    logic        start2 = 1'b0;
    logic        busy2, done2, tt_valid2, tt_last2;
    logic        tt_ready2 = 1'b1;
    logic [7:0]  x2;
    logic [15:0] tt_data2;
    logic        y2a = 1'b0, y2b = 1'b0;

`ifdef TT_SCAN_SIG_EN
    logic [15:0] sig0, sig2;
    logic        sig_valid0, sig_valid2;
`endif

    int checks = 0;
    int errors = 0;

    logic [16:0] q0[$];
    logic [16:0] q2[$];

    always #5 clk = ~clk;

    tt_scan_driver #(.N_IN(8), .OUT_W(16), .EVAL_LAT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .busy(busy0), .done(done0),
        .x_o(x0), .y_i(y0), .tt_data(tt_data0), .tt_valid(tt_valid0),
        .tt_ready(tt_ready0), .tt_last(tt_last0)
`ifdef TT_SCAN_SIG_EN
        , .sig(sig0), .sig_valid(sig_valid0)
`endif
    );

    tt_scan_driver #(.N_IN(8), .OUT_W(16), .EVAL_LAT(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .busy(busy2), .done(done2),
        .x_o(x2), .y_i(y2b), .tt_data(tt_data2), .tt_valid(tt_valid2),
        .tt_ready(tt_ready2), .tt_last(tt_last2)
`ifdef TT_SCAN_SIG_EN
        , .sig(sig2), .sig_valid(sig_valid2)
`endif
    );

    always_comb begin
        case (ymode)
            1:       y0 = x0[0];
            2:       y0 = x0[4];
            3:       y0 = &x0;
            default: y0 = 1'b0;
        endcase
    end

    always @(posedge clk) begin
        y2a <= ^x2;
        y2b <= y2a;
    end

    // ---------------------------------------------------------- reference model
    function automatic logic model(input int mode, input int v);
        logic [7:0] vb;
        vb = v[7:0];
        case (mode)
            1:       return vb[0];
            2:       return vb[4];
            3:       return &vb;
            4:       return ^vb;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
        logic fb;
        fb = c[15] ^ b;
        return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input int dut, input int mode, output logic [15:0] crc);
        logic [16:0] w_exp;
        logic        b;
        crc = 16'hFFFF;
        for (int w = 0; w < 16; w++) begin
            w_exp = '0;
            for (int j = 0; j < 16; j++) begin
                b = model(mode, w * 16 + j);
                w_exp[j] = b;
                crc = crc_step(crc, b);
            end
            w_exp[16] = (w == 15);
            if (dut == 0) q0.push_back(w_exp);
            else          q2.push_back(w_exp);
        end
    endtask

    // ------------------------------------------------------ scoreboard monitors
    logic [16:0] e0, e2;

    always begin
        @(negedge clk);
        #2;
        if (rst_n && tt_valid0 && tt_ready0) begin
            checks++;
            if (q0.size() == 0) begin
                errors++;
                $display("FAIL sb0_extra_word actual=0x%0h required=none", {tt_last0, tt_data0});
            end else begin
                e0 = q0.pop_front();
                if ({tt_last0, tt_data0} !== e0) begin
                    errors++;
                    $display("FAIL sb0_word actual={last,data}=0x%0h required=0x%0h",
                             {tt_last0, tt_data0}, e0);
                end
            end
        end
        if (rst_n && tt_valid2 && tt_ready2) begin
            checks++;
            if (q2.size() == 0) begin
                errors++;
                $display("FAIL sb2_extra_word actual=0x%0h required=none", {tt_last2, tt_data2});
            end else begin
                e2 = q2.pop_front();
                if ({tt_last2, tt_data2} !== e2) begin
                    errors++;
                    $display("FAIL sb2_word actual={last,data}=0x%0h required=0x%0h",
                             {tt_last2, tt_data2}, e2);
                end
            end
        end
    end

    // ------------------------------------------------------------- scan driver
    task automatic scan(input int dut, input int mode, input bit stall,
                        input bit mid_start, input int exp_busy);
        logic [15:0] crc;
        logic [15:0] hold_data;
        logic [7:0]  hold_x;
        logic        bsy, dn, vld, rdy;
        logic [15:0] dat;
        logic [7:0]  xv;
        int n, busy_n, words_acc, stalled;
        bit timed_out;

        push_exp(dut, mode, crc);
        n = 0; busy_n = 0; words_acc = 0; stalled = 0; timed_out = 0;
        hold_data = '0; hold_x = '0;

        @(negedge clk);
        if (dut == 0) begin ymode = mode; start0 = 1'b1; end
        else          start2 = 1'b1;

        forever begin
            @(negedge clk);
            n++;
            if (dut == 0) start0 = (mid_start && n == 50);
            else          start2 = (mid_start && n == 50);
            bsy = (dut == 0) ? busy0 : busy2;
            dn  = (dut == 0) ? done0 : done2;
            vld = (dut == 0) ? tt_valid0 : tt_valid2;
            dat = (dut == 0) ? tt_data0 : tt_data2;
            xv  = (dut == 0) ? x0 : x2;

            if (n == 1) begin
                chk("first_busy", {31'd0, bsy}, 32'd1);
                chk("first_x", {24'd0, xv}, 32'd0);
            end
            if (bsy) busy_n++;

            rdy = 1'b1;
            if (stall && vld && words_acc == 3 && stalled < 5) begin
                rdy = 1'b0;
                if (stalled == 0) begin
                    hold_data = dat;
                    hold_x    = xv;
                end else begin
                    chk("stall_data_stable", {16'd0, dat}, {16'd0, hold_data});
                    chk("stall_x_hold", {24'd0, xv}, {24'd0, hold_x});
                end
                stalled++;
            end
            if (dut == 0) tt_ready0 = rdy;
            else          tt_ready2 = rdy;
            if (vld && rdy) words_acc++;

            if (dn) break;
            if (n > exp_busy + 100) begin
                timed_out = 1;
                break;
            end
        end

        if (timed_out) begin
            errors++;
            $display("FAIL scan_timeout actual=no_done required=done_by_cycle_%0d", exp_busy + 1);
        end
        chk("done_latency", n, exp_busy + 1);
        chk("busy_cycles", busy_n, exp_busy);
        chk("words_accepted", words_acc, 16);
`ifdef TT_SCAN_SIG_EN
        if (dut == 0) begin
            chk("sig_valid_with_done", {31'd0, sig_valid0}, 32'd1);
            chk("sig_value", {16'd0, sig0}, {16'd0, crc});
        end else begin
            chk("sig_valid_with_done", {31'd0, sig_valid2}, 32'd1);
            chk("sig_value", {16'd0, sig2}, {16'd0, crc});
        end
`endif

        @(negedge clk);
        dn = (dut == 0) ? done0 : done2;
        xv = (dut == 0) ? x0 : x2;
        chk("done_one_cycle", {31'd0, dn}, 32'd0);
        chk("idle_x_zero", {24'd0, xv}, 32'd0);
`ifdef TT_SCAN_SIG_EN
        if (dut == 0) chk("sig_hold", {15'd0, sig_valid0, sig0}, {16'd0, crc});
        else          chk("sig_hold", {15'd0, sig_valid2, sig2}, {16'd0, crc});
`endif
        #3;
        if (dut == 0) begin
            chk("sb0_queue_empty", q0.size(), 0);
            q0.delete();
        end else begin
            chk("sb2_queue_empty", q2.size(), 0);
            q2.delete();
        end
    endtask

    // -------------------------------------------------------------- main stimulus
    initial begin : main
        logic [15:0] crc_unused;
        int n;
        bit reached;

        repeat (3) @(negedge clk);
        chk("reset_outputs0", {busy0, done0, tt_valid0, tt_last0, x0, tt_data0}, 32'd0);
        chk("reset_outputs2", {busy2, done2, tt_valid2, tt_last2, x2, tt_data2}, 32'd0);
`ifdef TT_SCAN_SIG_EN
        chk("reset_sig", {15'd0, sig_valid0, sig0}, 32'h0000FFFF);
`endif
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        scan(0, 0, 0, 0, 272);   // y tied low
        scan(0, 1, 0, 0, 272);   // y = x0 -> 0xAAAA
        scan(0, 2, 0, 0, 272);   // y = x4 -> alternating words
        scan(0, 3, 0, 0, 272);   // y = AND -> 0x8000 in the last word
        scan(0, 1, 1, 0, 277);   // 5-cycle back-pressure on word 3

        // asynchronous reset in the middle of a scan
        push_exp(0, 3, crc_unused);
        @(negedge clk);
        ymode  = 3;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        reached = 0;
        for (n = 0; n < 400; n++) begin
            if (x0 == 8'd100 && busy0) begin
                reached = 1;
                break;
            end
            @(negedge clk);
        end
        chk("reached_idx100", {31'd0, reached}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", {busy0, done0, tt_valid0, tt_last0, x0, tt_data0}, 32'd0);
        q0.delete();
        @(negedge clk);
        chk("reset_held_outputs", {busy0, done0, tt_valid0, tt_last0, x0, tt_data0}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        scan(0, 3, 0, 1, 272);   // fresh scan, start pulsed mid-scan is ignored
        scan(2, 4, 0, 0, 784);   // EVAL_LAT=2 registered parity netlist

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
